// File: rtl/mips_pkg.sv
// ============================================================================
// mips_pkg : shared types and constants for the MIPS memory/write-back stage.
// Revision : 1.0
// ============================================================================
`default_nettype none

package mips_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } mem_state_t;

  localparam logic [4:0] REG_ZERO   = 5'd0;
  localparam int         WORD_SHIFT = 2;

  // Register-file write enable; writes to $0 never reach the register file.
  function automatic logic writes_reg(input logic valid,
                                      input logic reg_write,
                                      input logic [4:0] dest);
    return valid & reg_write & (dest != REG_ZERO);
  endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_handshake_fsm.sv
// ============================================================================
// dmem_handshake_fsm : data-memory req/ack sequencer with request latches.
// Revision : 1.0
// ============================================================================
`default_nettype none

module dmem_handshake_fsm
  import mips_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ex_mem_valid,
  input  logic [DATA_WIDTH-1:0] ex_mem_alu_result,
  input  logic [DATA_WIDTH-1:0] ex_mem_store_data,
  input  logic [4:0]            ex_mem_destination_reg,
  input  logic                  ex_mem_mem_to_reg,
  input  logic                  ex_mem_mem_read,
  input  logic                  ex_mem_mem_write,
  input  logic                  ex_mem_reg_write,
  input  logic                  dmem_ack,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [ADDR_WIDTH-1:0] dmem_addr,
  output logic [DATA_WIDTH-1:0] dmem_wdata,
  output logic                  mem_stall,
  output logic                  pass_through,
  output logic                  access_done,
  output logic [4:0]            lat_dest,
  output logic                  lat_mem_to_reg,
  output logic                  lat_reg_write,
  output logic [DATA_WIDTH-1:0] lat_alu_result
);

  mem_state_t r_state;
  mem_state_t w_next_state;
  logic       w_launch;
  logic       w_stall;
  logic       w_mem_op;

  assign w_mem_op = ex_mem_mem_read | ex_mem_mem_write;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_launch     = 1'b0;
    w_stall      = 1'b0;
    pass_through = 1'b0;
    access_done  = 1'b0;
    case (r_state)
      IDLE: begin
        if (ex_mem_valid && w_mem_op) begin
          w_launch     = 1'b1;
          w_stall      = 1'b1;
          w_next_state = ACCESS;
        end else if (ex_mem_valid) begin
          pass_through = 1'b1;
        end
      end
      ACCESS: begin
        if (dmem_ack) begin
          access_done  = 1'b1;
          w_next_state = IDLE;
        end else begin
          w_stall = 1'b1;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Stall is forced low during reset so upstream is never frozen by stale inputs.
  assign mem_stall = w_stall & ~reset;
  // Request is exactly the ACCESS state, so reset withdraws it asynchronously.
  assign dmem_req  = (r_state == ACCESS);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dmem_we        <= 1'b0;
      dmem_addr      <= '0;
      dmem_wdata     <= '0;
      lat_dest       <= REG_ZERO;
      lat_mem_to_reg <= 1'b0;
      lat_reg_write  <= 1'b0;
      lat_alu_result <= '0;
    end else if (w_launch) begin
      // Read and write both set resolves to a store.
      dmem_we        <= ex_mem_mem_write;
      dmem_addr      <= ex_mem_alu_result[ADDR_WIDTH+WORD_SHIFT-1:WORD_SHIFT];
      dmem_wdata     <= ex_mem_store_data;
      lat_dest       <= ex_mem_destination_reg;
      lat_mem_to_reg <= ex_mem_mem_to_reg;
      lat_reg_write  <= ex_mem_reg_write;
      lat_alu_result <= ex_mem_alu_result;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_wb_pipe_stage.sv
// ============================================================================
// mem_wb_pipe_stage : MIPS MEM stage with MEM/WB register feeding the regfile.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mem_wb_pipe_stage
  import mips_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ex_mem_valid,
  input  logic [DATA_WIDTH-1:0] ex_mem_alu_result,
  input  logic [DATA_WIDTH-1:0] ex_mem_store_data,
  input  logic [4:0]            ex_mem_destination_reg,
  input  logic                  ex_mem_mem_to_reg,
  input  logic                  ex_mem_mem_read,
  input  logic                  ex_mem_mem_write,
  input  logic                  ex_mem_reg_write,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [ADDR_WIDTH-1:0] dmem_addr,
  output logic [DATA_WIDTH-1:0] dmem_wdata,
  input  logic                  dmem_ack,
  input  logic [DATA_WIDTH-1:0] dmem_rdata,
  output logic                  mem_stall,
  output logic                  mem_wb_valid,
  output logic                  mem_wb_reg_write,
  output logic [4:0]            mem_wb_write_reg_addr,
  output logic [DATA_WIDTH-1:0] mem_wb_write_back_data
);

  logic                  w_pass_through;
  logic                  w_access_done;
  logic [4:0]            w_lat_dest;
  logic                  w_lat_mem_to_reg;
  logic                  w_lat_reg_write;
  logic [DATA_WIDTH-1:0] w_lat_alu_result;

  dmem_handshake_fsm #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_fsm (
    .clk                    (clk),
    .reset                  (reset),
    .ex_mem_valid           (ex_mem_valid),
    .ex_mem_alu_result      (ex_mem_alu_result),
    .ex_mem_store_data      (ex_mem_store_data),
    .ex_mem_destination_reg (ex_mem_destination_reg),
    .ex_mem_mem_to_reg      (ex_mem_mem_to_reg),
    .ex_mem_mem_read        (ex_mem_mem_read),
    .ex_mem_mem_write       (ex_mem_mem_write),
    .ex_mem_reg_write       (ex_mem_reg_write),
    .dmem_ack               (dmem_ack),
    .dmem_req               (dmem_req),
    .dmem_we                (dmem_we),
    .dmem_addr              (dmem_addr),
    .dmem_wdata             (dmem_wdata),
    .mem_stall              (mem_stall),
    .pass_through           (w_pass_through),
    .access_done            (w_access_done),
    .lat_dest               (w_lat_dest),
    .lat_mem_to_reg         (w_lat_mem_to_reg),
    .lat_reg_write          (w_lat_reg_write),
    .lat_alu_result         (w_lat_alu_result)
  );

  // Every cycle that neither passes an ALU op nor completes an access is a bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_wb_valid           <= 1'b0;
      mem_wb_reg_write       <= 1'b0;
      mem_wb_write_reg_addr  <= REG_ZERO;
      mem_wb_write_back_data <= '0;
    end else if (w_pass_through) begin
      mem_wb_valid           <= 1'b1;
      mem_wb_reg_write       <= writes_reg(1'b1, ex_mem_reg_write, ex_mem_destination_reg);
      mem_wb_write_reg_addr  <= ex_mem_destination_reg;
      mem_wb_write_back_data <= ex_mem_alu_result;
    end else if (w_access_done) begin
      mem_wb_valid           <= 1'b1;
      mem_wb_reg_write       <= writes_reg(1'b1, w_lat_reg_write, w_lat_dest);
      mem_wb_write_reg_addr  <= w_lat_dest;
      mem_wb_write_back_data <= w_lat_mem_to_reg ? dmem_rdata : w_lat_alu_result;
    end else begin
      mem_wb_valid     <= 1'b0;
      mem_wb_reg_write <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_wb_pipe_stage.sv
// ============================================================================
// tb_mem_wb_pipe_stage : directed bench for the MIPS MEM/WB stage.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mem_wb_pipe_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_mem_valid;
  logic [31:0] ex_mem_alu_result;
  logic [31:0] ex_mem_store_data;
  logic [4:0]  ex_mem_destination_reg;
  logic        ex_mem_mem_to_reg;
  logic        ex_mem_mem_read;
  logic        ex_mem_mem_write;
  logic        ex_mem_reg_write;
  logic        dmem_req;
  logic        dmem_we;
  logic [9:0]  dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        mem_stall;
  logic        mem_wb_valid;
  logic        mem_wb_reg_write;
  logic [4:0]  mem_wb_write_reg_addr;
  logic [31:0] mem_wb_write_back_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_wb_pipe_stage #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .ex_mem_valid           (ex_mem_valid),
    .ex_mem_alu_result      (ex_mem_alu_result),
    .ex_mem_store_data      (ex_mem_store_data),
    .ex_mem_destination_reg (ex_mem_destination_reg),
    .ex_mem_mem_to_reg      (ex_mem_mem_to_reg),
    .ex_mem_mem_read        (ex_mem_mem_read),
    .ex_mem_mem_write       (ex_mem_mem_write),
    .ex_mem_reg_write       (ex_mem_reg_write),
    .dmem_req               (dmem_req),
    .dmem_we                (dmem_we),
    .dmem_addr              (dmem_addr),
    .dmem_wdata             (dmem_wdata),
    .dmem_ack               (dmem_ack),
    .dmem_rdata             (dmem_rdata),
    .mem_stall              (mem_stall),
    .mem_wb_valid           (mem_wb_valid),
    .mem_wb_reg_write       (mem_wb_reg_write),
    .mem_wb_write_reg_addr  (mem_wb_write_reg_addr),
    .mem_wb_write_back_data (mem_wb_write_back_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic v, input logic [31:0] alu, input logic [31:0] sd,
                        input logic [4:0] dest, input logic m2r, input logic mr,
                        input logic mw, input logic rw);
    ex_mem_valid           = v;
    ex_mem_alu_result      = alu;
    ex_mem_store_data      = sd;
    ex_mem_destination_reg = dest;
    ex_mem_mem_to_reg      = m2r;
    ex_mem_mem_read        = mr;
    ex_mem_mem_write       = mw;
    ex_mem_reg_write       = rw;
  endtask

  task automatic bubble();
    set_op(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk_wb(input string tag, input logic v, input logic rw,
                        input logic [4:0] a, input logic [31:0] d);
    chk({tag, "_valid"}, 32'(mem_wb_valid), 32'(v));
    chk({tag, "_rw"},    32'(mem_wb_reg_write), 32'(rw));
    chk({tag, "_addr"},  32'(mem_wb_write_reg_addr), 32'(a));
    chk({tag, "_data"},  mem_wb_write_back_data, d);
  endtask

  initial begin
    reset = 1'b1;
    dmem_ack = 1'b0;
    dmem_rdata = 32'h0;
    bubble();
    step();
    // Memory op presented during reset must not stall.
    set_op(1'b1, 32'h40, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1);
    #1;
    chk("rst_stall", 32'(mem_stall), 32'h0);
    chk("rst_req",   32'(dmem_req), 32'h0);
    chk("rst_we",    32'(dmem_we), 32'h0);
    chk("rst_addr",  32'(dmem_addr), 32'h0);
    chk("rst_wdata", dmem_wdata, 32'h0);
    chk_wb("rst", 1'b0, 1'b0, 5'd0, 32'h0);
    bubble();
    step();
    reset = 1'b0;
    step();

    // ALU op, no memory access.
    set_op(1'b1, 32'h14, 32'h0, 5'd8, 1'b0, 1'b0, 1'b0, 1'b1);
    #1;
    chk("alu_stall", 32'(mem_stall), 32'h0);
    step();
    bubble();
    chk_wb("alu", 1'b1, 1'b1, 5'd8, 32'h14);
    chk("alu_stall_after", 32'(mem_stall), 32'h0);

    // lw, ack in the third ACCESS cycle: three stall cycles.
    set_op(1'b1, 32'h40, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1);
    #1;
    chk("lw_stall1", 32'(mem_stall), 32'h1);
    step();
    chk("lw_req", 32'(dmem_req), 32'h1);
    chk("lw_we", 32'(dmem_we), 32'h0);
    chk("lw_addr", 32'(dmem_addr), 32'h010);
    chk("lw_stall2", 32'(mem_stall), 32'h1);
    chk("lw_bub1_rw", 32'(mem_wb_reg_write), 32'h0);
    chk("lw_bub1_v", 32'(mem_wb_valid), 32'h0);
    step();
    chk("lw_stall3", 32'(mem_stall), 32'h1);
    chk("lw_req2", 32'(dmem_req), 32'h1);
    chk("lw_bub2_rw", 32'(mem_wb_reg_write), 32'h0);
    step();
    dmem_ack = 1'b1;
    dmem_rdata = 32'hDEAD_BEEF;
    #1;
    chk("lw_ack_stall", 32'(mem_stall), 32'h0);
    chk("lw_bub3_rw", 32'(mem_wb_reg_write), 32'h0);
    step();
    dmem_ack = 1'b0;
    dmem_rdata = 32'h0;
    bubble();
    chk_wb("lw", 1'b1, 1'b1, 5'd9, 32'hDEAD_BEEF);
    chk("lw_req_drop", 32'(dmem_req), 32'h0);

    // sw, ack in the first ACCESS cycle.
    set_op(1'b1, 32'h8, 32'h1234_5678, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    #1;
    chk("sw_stall1", 32'(mem_stall), 32'h1);
    step();
    chk("sw_req", 32'(dmem_req), 32'h1);
    chk("sw_we", 32'(dmem_we), 32'h1);
    chk("sw_addr", 32'(dmem_addr), 32'h2);
    chk("sw_wdata", dmem_wdata, 32'h1234_5678);
    dmem_ack = 1'b1;
    #1;
    chk("sw_ack_stall", 32'(mem_stall), 32'h0);
    step();
    dmem_ack = 1'b0;
    bubble();
    chk("sw_req_drop", 32'(dmem_req), 32'h0);
    chk("sw_valid", 32'(mem_wb_valid), 32'h1);
    chk("sw_rw", 32'(mem_wb_reg_write), 32'h0);

    // ALU op targeting $0.
    set_op(1'b1, 32'h55, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    bubble();
    chk_wb("r0", 1'b1, 1'b0, 5'd0, 32'h55);

    // Back-to-back loads, each acked in the second ACCESS cycle.
    set_op(1'b1, 32'h100, 32'h0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1);
    step();
    chk("b2b_req1", 32'(dmem_req), 32'h1);
    chk("b2b_addr1", 32'(dmem_addr), 32'h040);
    step();
    dmem_ack = 1'b1;
    dmem_rdata = 32'h1111_1111;
    step();
    dmem_ack = 1'b0;
    chk("b2b_gap", 32'(dmem_req), 32'h0);
    chk_wb("b2b1", 1'b1, 1'b1, 5'd3, 32'h1111_1111);
    set_op(1'b1, 32'h104, 32'h0, 5'd4, 1'b1, 1'b1, 1'b0, 1'b1);
    #1;
    chk("b2b_stall2", 32'(mem_stall), 32'h1);
    step();
    chk("b2b_req2", 32'(dmem_req), 32'h1);
    chk("b2b_addr2", 32'(dmem_addr), 32'h041);
    chk("b2b_bub_v", 32'(mem_wb_valid), 32'h0);
    step();
    dmem_ack = 1'b1;
    dmem_rdata = 32'h2222_2222;
    step();
    dmem_ack = 1'b0;
    bubble();
    chk("b2b_req_drop", 32'(dmem_req), 32'h0);
    chk_wb("b2b2", 1'b1, 1'b1, 5'd4, 32'h2222_2222);

    // Reset two cycles into ACCESS, then a stray ack after release.
    set_op(1'b1, 32'h20, 32'h0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1);
    step();
    step();
    chk("mid_req_before", 32'(dmem_req), 32'h1);
    reset = 1'b1;
    #1;
    chk("mid_req_async", 32'(dmem_req), 32'h0);
    chk("mid_stall", 32'(mem_stall), 32'h0);
    chk("mid_addr", 32'(dmem_addr), 32'h0);
    chk_wb("mid", 1'b0, 1'b0, 5'd0, 32'h0);
    bubble();
    step();
    reset = 1'b0;
    step();
    dmem_ack = 1'b1;
    dmem_rdata = 32'hFFFF_FFFF;
    #1;
    chk("stray_stall", 32'(mem_stall), 32'h0);
    step();
    dmem_ack = 1'b0;
    chk("stray_req", 32'(dmem_req), 32'h0);
    chk_wb("stray", 1'b0, 1'b0, 5'd0, 32'h0);
    set_op(1'b1, 32'h77, 32'h0, 5'd7, 1'b0, 1'b0, 1'b0, 1'b1);
    #1;
    chk("post_stall", 32'(mem_stall), 32'h0);
    step();
    bubble();
    chk_wb("post", 1'b1, 1'b1, 5'd7, 32'h77);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
